// File: rtl/stop_watch_gen.sv
// Parametrised BCD stopwatch: prescaled up/down counting, wrap or saturate, preset, lap freeze, overflow pulse.
// Defining SW_SEGMENT_MUX_EN adds a multiplexed 7-segment driver (an/seg ports).
module stop_watch_gen #(
  parameter int DIGITS      = 4,
  parameter int N           = 10,
  parameter int WRAP        = 1,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                clr,
  input  logic                up,
  input  logic                load,
  input  logic [DIGITS*4-1:0] load_val,
  input  logic                lap,
  output logic [DIGITS*4-1:0] d,
  output logic                tick,
  output logic                ovf
`ifdef SW_SEGMENT_MUX_EN
  ,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg
`endif
);

  localparam int W  = DIGITS * 4;
  localparam int PW = $clog2(N);

  if (DIGITS < 1 || DIGITS > 8 || N < 2 || REFRESH_DIV < 1) begin : g_param_check
    $error("stop_watch_gen: parameter out of range");
  end

  function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic dn);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (!dn) begin
          if (v[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
          else begin
            r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (v[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'd9;
          else begin
            r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  logic [PW-1:0] presc_q;
  logic          tick_q;
  logic          ovf_q;
  logic [W-1:0]  cnt_q;
  logic [W-1:0]  lap_q;
  logic          lap_prev_q;

  logic [W-1:0]  cnt_d;
  logic          lim_d;
  logic [W-1:0]  load_d;

  always_comb begin
    lim_d = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q[i*4 +: 4] != (up ? 4'd9 : 4'd0)) lim_d = 1'b0;
    end
    // Stepping past all-9s/all-0s already lands on the wrapped value.
    cnt_d = bcd_step(cnt_q, !up);
    if (lim_d && WRAP == 0) cnt_d = cnt_q;
  end

  always_comb begin
    load_d = load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[i*4 +: 4] > 4'd9) load_d[i*4 +: 4] = 4'd9;
    end
  end

  // tick_q marks the prescaler wrap; the count consumes it on the following edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q    <= '0;
      tick_q     <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      lap_q      <= '0;
      lap_prev_q <= 1'b0;
    end else begin
      lap_prev_q <= lap;
      tick_q     <= 1'b0;
      ovf_q      <= 1'b0;
      if (clr) begin
        presc_q <= '0;
        cnt_q   <= '0;
        if (lap) lap_q <= '0;
      end else begin
        if (start) begin
          if (presc_q == PW'(N - 1)) begin
            presc_q <= '0;
            tick_q  <= 1'b1;
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        if (load) begin
          cnt_q <= load_d;
        end else if (tick_q) begin
          cnt_q <= cnt_d;
          ovf_q <= lim_d;
        end
        if (lap && !lap_prev_q) lap_q <= cnt_q;
      end
    end
  end

  // On the lap rising cycle the lap register is still loading, so show the live count.
  assign d    = (lap && lap_prev_q) ? lap_q : cnt_q;
  assign tick = tick_q;
  assign ovf  = ovf_q;

`ifdef SW_SEGMENT_MUX_EN
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [6:0] seg_dec(input logic [3:0] v);
    case (v)
      4'd0:    seg_dec = 7'h40;
      4'd1:    seg_dec = 7'h79;
      4'd2:    seg_dec = 7'h24;
      4'd3:    seg_dec = 7'h30;
      4'd4:    seg_dec = 7'h19;
      4'd5:    seg_dec = 7'h12;
      4'd6:    seg_dec = 7'h02;
      4'd7:    seg_dec = 7'h78;
      4'd8:    seg_dec = 7'h00;
      4'd9:    seg_dec = 7'h10;
      default: seg_dec = 7'h7f;
    endcase
  endfunction

  logic [RW-1:0]     ref_q;
  logic [SW-1:0]     sel_q;
  logic [DIGITS-1:0] an_q;
  logic [6:0]        seg_q;

  // sel_q names the digit that the next refresh slot will show.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_q <= '0;
      sel_q <= '0;
      an_q  <= ~DIGITS'(1);
      seg_q <= 7'h7f;
    end else if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_q <= '0;
      an_q  <= ~(DIGITS'(1) << sel_q);
      seg_q <= seg_dec(d[sel_q*4 +: 4]);
      sel_q <= (sel_q == SW'(DIGITS - 1)) ? '0 : sel_q + SW'(1);
    end else begin
      ref_q <= ref_q + RW'(1);
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
`endif

endmodule
